// File: rtl/niosqsys_led_pio_pkg.sv
// Shared register map and default widths for the LED output PIO.
package niosqsys_led_pio_pkg;

    localparam int DEF_WIDTH      = 4;
    localparam int DEF_PRESCALE_W = 24;

    localparam logic [2:0] ADDR_DATA         = 3'd0;
    localparam logic [2:0] ADDR_BLINK_MASK   = 3'd1;
    localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd2;
    localparam logic [2:0] ADDR_OUTSET       = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR     = 3'd5;

endpackage

// File: rtl/niosqsys_led_pio_blink_timer.sv
// Blink phase generator: phase toggles every period+1 cycles; a load restarts
// the count at the supplied period with phase forced high.
module niosqsys_led_pio_blink_timer
    import niosqsys_led_pio_pkg::*;
#(
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PRESCALE_W-1:0] period,
    input  logic                  load,
    output logic                  phase
);

    logic [PRESCALE_W-1:0] cnt_r;
    logic                  phase_r;

    // Down-counter and phase flop; a load outranks a coincident expiry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r   <= {PRESCALE_W{1'b0}};
            phase_r <= 1'b1;
        end else if (load) begin
            cnt_r   <= period;
            phase_r <= 1'b1;
        end else if (period == {PRESCALE_W{1'b0}}) begin
            cnt_r   <= {PRESCALE_W{1'b0}};
            phase_r <= 1'b1;
        end else if (cnt_r == {PRESCALE_W{1'b0}}) begin
            cnt_r   <= period;
            phase_r <= ~phase_r;
        end else begin
            cnt_r   <= cnt_r - {{(PRESCALE_W-1){1'b0}}, 1'b1};
            phase_r <= phase_r;
        end
    end

    assign phase = phase_r;

endmodule

// File: rtl/niosqsys_led_pio.sv
// Avalon-MM LED output PIO with set/clear aliases and an optional blink engine,
// enabled by defining NIOSQSYS_LED_PIO_BLINK_EN.
module niosqsys_led_pio
    import niosqsys_led_pio_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter int               PRESCALE_W  = DEF_PRESCALE_W,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [2:0]       address,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic             wr_s;
    logic [WIDTH-1:0] wd_s;
    logic [WIDTH-1:0] data_r;
    logic [31:0]      rd_s;
    logic             unused_wd_s;

    assign wr_s        = chipselect & ~write_n;
    assign wd_s        = writedata[WIDTH-1:0];
    assign unused_wd_s = ^writedata;

    // DATA register with direct write and atomic set/clear aliases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r <= RESET_VALUE;
        end else if (wr_s) begin
            case (address)
                ADDR_DATA:     data_r <= wd_s;
                ADDR_OUTSET:   data_r <= data_r | wd_s;
                ADDR_OUTCLEAR: data_r <= data_r & ~wd_s;
                default:       data_r <= data_r;
            endcase
        end else begin
            data_r <= data_r;
        end
    end

`ifdef NIOSQSYS_LED_PIO_BLINK_EN
    logic [WIDTH-1:0]      blink_mask_r;
    logic [PRESCALE_W-1:0] blink_period_r;
    logic [PRESCALE_W-1:0] period_s;
    logic                  load_s;
    logic                  phase_s;

    assign load_s   = wr_s && (address == ADDR_BLINK_PERIOD);
    // The timer must see the value being written on the load edge itself.
    assign period_s = load_s ? writedata[PRESCALE_W-1:0] : blink_period_r;

    // Blink mask and period registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_mask_r   <= {WIDTH{1'b0}};
            blink_period_r <= {PRESCALE_W{1'b0}};
        end else if (wr_s && (address == ADDR_BLINK_MASK)) begin
            blink_mask_r   <= wd_s;
            blink_period_r <= blink_period_r;
        end else if (load_s) begin
            blink_mask_r   <= blink_mask_r;
            blink_period_r <= writedata[PRESCALE_W-1:0];
        end else begin
            blink_mask_r   <= blink_mask_r;
            blink_period_r <= blink_period_r;
        end
    end

    niosqsys_led_pio_blink_timer #(
        .PRESCALE_W (PRESCALE_W)
    ) u_blink_timer (
        .clk    (clk),
        .reset  (reset),
        .period (period_s),
        .load   (load_s),
        .phase  (phase_s)
    );

    assign out_port = data_r & (~blink_mask_r | {WIDTH{phase_s}});
`else
    logic [PRESCALE_W-1:0] unused_period_s;
    assign unused_period_s = writedata[PRESCALE_W-1:0];
    assign out_port        = data_r;
`endif

    // Read mux; unimplemented and write-only addresses return zero.
    always_comb begin
        rd_s = 32'h0000_0000;
        case (address)
            ADDR_DATA:         rd_s = 32'(data_r);
`ifdef NIOSQSYS_LED_PIO_BLINK_EN
            ADDR_BLINK_MASK:   rd_s = 32'(blink_mask_r);
            ADDR_BLINK_PERIOD: rd_s = 32'(blink_period_r);
`endif
            default:           rd_s = 32'h0000_0000;
        endcase
    end

    // Registered read data, refreshed every cycle regardless of chipselect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= 32'h0000_0000;
        end else begin
            readdata <= rd_s;
        end
    end

endmodule

// File: tb/tb_niosqsys_led_pio.sv
// Randomised self-checking bench for niosqsys_led_pio against a behavioural model.
module tb_niosqsys_led_pio;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [2:0]  address = 3'd0;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata;
    logic [3:0]  out_port;
    logic [31:0] rv_readdata;
    logic [3:0]  rv_out_port;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: blink phase is derived from edges elapsed since the last period load.
    logic [3:0]  m_data = 4'h0;
    logic [3:0]  m_mask = 4'h0;
    int          m_period = 0;
    int          m_k = 0;
    logic [31:0] m_rd = 32'h0;

    niosqsys_led_pio u_dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write_n(write_n),
        .address(address), .writedata(writedata), .readdata(readdata), .out_port(out_port)
    );

    niosqsys_led_pio #(.RESET_VALUE(4'hA)) u_dut_rv (
        .clk(clk), .reset(reset), .chipselect(1'b0), .write_n(1'b1),
        .address(3'd0), .writedata(32'h0), .readdata(rv_readdata), .out_port(rv_out_port)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_phase();
        if (m_period == 0) return 1'b1;
        return ((m_k / (m_period + 1)) % 2) == 0;
    endfunction

    function automatic logic [3:0] m_out();
        return m_data & (~m_mask | {4{m_phase()}});
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return {28'h0, m_data};
`ifdef NIOSQSYS_LED_PIO_BLINK_EN
            3'd1: return {28'h0, m_mask};
            3'd2: return m_period;
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_data = 4'h0; m_mask = 4'h0; m_period = 0; m_k = 0; m_rd = 32'h0;
    endtask

    task automatic model_edge();
        logic loaded;
        loaded = 1'b0;
        if (reset) return;
        m_rd = m_read(address);
        if (chipselect && !write_n) begin
            case (address)
                3'd0: m_data = writedata[3:0];
`ifdef NIOSQSYS_LED_PIO_BLINK_EN
                3'd1: m_mask = writedata[3:0];
                3'd2: begin m_period = int'(writedata[23:0]); loaded = 1'b1; end
`endif
                3'd4: m_data = m_data | writedata[3:0];
                3'd5: m_data = m_data & ~writedata[3:0];
                default: ;
            endcase
        end
        if (loaded) m_k = 0;
        else        m_k++;
    endtask

    task automatic step(input logic c, input logic wn, input logic [2:0] a, input logic [31:0] d);
        chipselect = c; write_n = wn; address = a; writedata = d;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        step(1'b1, 1'b0, a, d);
    endtask

    task automatic idle(input logic [2:0] a);
        step(1'b0, 1'b1, a, 32'h0);
    endtask

    // Cycle-by-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        chk("cmp_out_port", {28'h0, out_port}, {28'h0, m_out()});
        chk("cmp_readdata", readdata, m_rd);
    end

    initial begin
        logic [2:0]  ra;
        logic [31:0] rd;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_out_port", {28'h0, out_port}, 32'h0);
        chk("reset_rv_out_port", {28'h0, rv_out_port}, 32'hA);
        for (int a = 0; a < 8; a++) begin
            idle(3'(a));
            chk("reset_read", readdata, 32'h0);
        end
        chk("reset_rv_read", rv_readdata, 32'hA);

        wr(3'd0, 32'hFFFF_FFF5);
        chk("data_write", {28'h0, out_port}, 32'h5);
        wr(3'd4, 32'h2);
        chk("outset", {28'h0, out_port}, 32'h7);
        wr(3'd5, 32'h4);
        chk("outclear", {28'h0, out_port}, 32'h3);
        idle(3'd0);
        chk("read_data", readdata, 32'h3);
        idle(3'd4);
        chk("read_outset", readdata, 32'h0);
        idle(3'd5);
        chk("read_outclear", readdata, 32'h0);

`ifdef NIOSQSYS_LED_PIO_BLINK_EN
        wr(3'd0, 32'hF);
        wr(3'd1, 32'h3);
        wr(3'd2, 32'h4);
        for (int i = 0; i < 10; i++) begin
            chk("blink_p4", {28'h0, out_port}, (i < 5) ? 32'hF : 32'hC);
            idle(3'd2);
        end
        for (int i = 0; i < 20 && !(!m_phase() && (m_k % (m_period + 1)) == m_period); i++)
            idle(3'd0);
        chk("blink_find_expiry", {28'h0, out_port}, 32'hC);
        wr(3'd2, 32'h2);
        for (int i = 0; i < 6; i++) begin
            chk("blink_p2", {28'h0, out_port}, (i < 3) ? 32'hF : 32'hC);
            idle(3'd0);
        end
        wr(3'd2, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk("blink_p0_hold", {28'h0, out_port}, 32'hF);
            idle(3'd0);
        end
`else
        wr(3'd1, 32'hF);
        wr(3'd2, 32'h1);
        wr(3'd0, 32'h6);
        idle(3'd1);
        chk("noblink_read_mask", readdata, 32'h0);
        idle(3'd2);
        chk("noblink_read_period", readdata, 32'h0);
        for (int i = 0; i < 6; i++) begin
            chk("noblink_steady", {28'h0, out_port}, 32'h6);
            idle(3'd0);
        end
`endif

        wr(3'd0, 32'h9);
        wr(3'd1, 32'hF);
        wr(3'd2, 32'h3);
        repeat (4) idle(3'd0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_reset_out", {28'h0, out_port}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            idle(3'(a));
            chk("post_reset_read", readdata, 32'h0);
        end

        repeat (400) begin
            ra = 3'($urandom_range(0, 7));
            rd = $urandom;
            if (ra == 3'd2) rd = $urandom_range(0, 6);
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), ra, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
